// File: rtl/dot_count.sv
// Registered neighbour population count for a Game-of-Life cell: full count,
// Life-rule survival/birth code and an overcrowding flag, all from one sample.
module dot_count (
  input  logic       Clock,
  input  logic       reset,
  input  logic [7:0] neighborDot,
  output logic [1:0] counter,
  output logic [3:0] count,
  output logic       overcrowd
);

  logic [3:0] pop_cnt;
  logic [1:0] life_code;
  logic       crowded;

  // Four-bit accumulator so that all eight neighbours alive yields 4'd8.
  always_comb begin
    pop_cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      pop_cnt = pop_cnt + {3'b000, neighborDot[i]};
    end
  end

  // Counts of four or more saturate to 00: no survival and no birth.
  always_comb begin
    crowded   = (pop_cnt >= 4'd4);
    life_code = crowded ? 2'b00 : pop_cnt[1:0];
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      counter   <= 2'b00;
      count     <= 4'd0;
      overcrowd <= 1'b0;
    end else begin
      counter   <= life_code;
      count     <= pop_cnt;
      overcrowd <= crowded;
    end
  end

endmodule

// File: tb/tb_dot_count.sv
// Self-checking bench for dot_count: directed steps, exhaustive sweep and
// randomized stream against a popcount reference model.
module tb_dot_count;

  logic       Clock;
  logic       reset;
  logic [7:0] neighborDot;
  logic [1:0] counter;
  logic [3:0] count;
  logic       overcrowd;

  int total;
  int bad;

  dot_count dut (
    .Clock      (Clock),
    .reset      (reset),
    .neighborDot(neighborDot),
    .counter    (counter),
    .count      (count),
    .overcrowd  (overcrowd)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then sample 1 time unit later.
  task automatic step(input logic rst, input logic [7:0] nd);
    reset       = rst;
    neighborDot = nd;
    @(posedge Clock);
    #1;
  endtask

  // Reference: Life rules applied to the number of live neighbours.
  task automatic check_model(input string tag, input logic rst, input logic [7:0] nd);
    int n;
    logic [3:0] exp_count;
    logic [1:0] exp_code;
    logic       exp_over;
    n = $countones(nd);
    if (rst) begin
      exp_count = 4'd0;
      exp_code  = 2'b00;
      exp_over  = 1'b0;
    end else begin
      exp_count = 4'(n);
      exp_over  = (n >= 4);
      case (n)
        1:       exp_code = 2'b01;
        2:       exp_code = 2'b10;
        3:       exp_code = 2'b11;
        default: exp_code = 2'b00;
      endcase
    end
    check({tag, ".count"}, count, exp_count);
    check({tag, ".counter"}, {2'b00, counter}, {2'b00, exp_code});
    check({tag, ".overcrowd"}, {3'b000, overcrowd}, {3'b000, exp_over});
  endtask

  initial begin
    logic       rst;
    logic [7:0] nd;
    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    neighborDot = 8'h00;
    @(negedge Clock);

    // Reset wins over an all-alive neighbourhood.
    step(1'b1, 8'hFF);
    check("rst_ff.count", count, 4'd0);
    check("rst_ff.counter", {2'b00, counter}, 4'd0);
    check("rst_ff.overcrowd", {3'b000, overcrowd}, 4'd0);

    // First edge out of reset reflects the input sampled there.
    step(1'b0, 8'b0000_0001);
    check("one_a.counter", {2'b00, counter}, 4'b0001);
    check("one_a.count", count, 4'd1);
    check("one_a.overcrowd", {3'b000, overcrowd}, 4'd0);
    step(1'b0, 8'b0000_0010);
    check("one_b.counter", {2'b00, counter}, 4'b0001);
    check("one_b.count", count, 4'd1);
    step(1'b0, 8'b0000_0100);
    check("one_c.counter", {2'b00, counter}, 4'b0001);
    check("one_c.count", count, 4'd1);
    check("one_c.overcrowd", {3'b000, overcrowd}, 4'd0);

    step(1'b0, 8'b0000_0011);
    check("two.counter", {2'b00, counter}, 4'b0010);
    check("two.count", count, 4'd2);

    step(1'b0, 8'b0000_0111);
    check("three.counter", {2'b00, counter}, 4'b0011);
    check("three.count", count, 4'd3);
    check("three.overcrowd", {3'b000, overcrowd}, 4'd0);

    step(1'b0, 8'b0000_1111);
    check("four.counter", {2'b00, counter}, 4'b0000);
    check("four.count", count, 4'd4);
    check("four.overcrowd", {3'b000, overcrowd}, 4'd1);

    step(1'b0, 8'b0011_1111);
    check("six.counter", {2'b00, counter}, 4'b0000);
    check("six.count", count, 4'd6);
    check("six.overcrowd", {3'b000, overcrowd}, 4'd1);

    step(1'b0, 8'hFF);
    check("eight.count", count, 4'd8);
    check("eight.counter", {2'b00, counter}, 4'b0000);
    check("eight.overcrowd", {3'b000, overcrowd}, 4'd1);

    // Mid-stream reset with a birth pattern on the same edge.
    step(1'b1, 8'b0000_0111);
    check("rst_mid.counter", {2'b00, counter}, 4'd0);
    check("rst_mid.count", count, 4'd0);
    check("rst_mid.overcrowd", {3'b000, overcrowd}, 4'd0);

    // Exhaustive sweep of every neighbourhood.
    for (int v = 0; v < 256; v++) begin
      nd = 8'(v);
      step(1'b0, nd);
      check_model("sweep", 1'b0, nd);
    end

    // Randomized stream with occasional resets; no history may leak through.
    for (int k = 0; k < 300; k++) begin
      nd  = 8'($urandom);
      rst = ($urandom_range(15) == 0);
      step(rst, nd);
      check_model("rand", rst, nd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dot_count.md
DOT_COUNT -- requirements
Module: dot_count

Interface
REQ-001 The block SHALL have no parameters; the neighbour vector width is fixed at 8.
REQ-002 The block SHALL have port `Clock`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port `reset`, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of `Clock`.
REQ-004 The block SHALL have port `neighborDot`, input, 8 bits: one bit per neighbouring cell; 1 = neighbour alive; bit order is irrelevant.
REQ-005 The block SHALL have port `counter`, output, 2 bits: the Life-rule neighbour code defined in REQ-010.
REQ-006 The block SHALL have port `count`, output, 4 bits: the full population count of `neighborDot`, range 0..8.
REQ-007 The block SHALL have port `overcrowd`, output, 1 bit: asserted when the population count is 4 or more.

Function
REQ-008 Let N be the number of 1 bits in `neighborDot`; N SHALL be computed with no width truncation, so N = 8 yields 4'd8.
REQ-009 On each rising `Clock` edge with `reset` = 0, `count` SHALL load N, so `count` has 1-cycle latency.
REQ-010 On the same edge, `counter` SHALL load this mapping of N:
- N = 0 -> 2'b00
- N = 1 -> 2'b01
- N = 2 -> 2'b10
- N = 3 -> 2'b11
- N >= 4 -> 2'b00 (saturate to "no survival, no birth")
REQ-011 Consequence of REQ-010: `counter[1]` = 1 exactly when N is 2 or 3 (survival), and `counter` = 2'b11 exactly when N = 3 (birth); the implementation SHALL preserve both properties.
REQ-012 On the same edge, `overcrowd` SHALL load (N >= 4).
REQ-013 All three outputs SHALL come directly from flip-flops, with no combinational path from `neighborDot` to any output.
REQ-014 The outputs SHALL always be mutually consistent, all describing the same sampled `neighborDot`.
REQ-015 The outputs SHALL be fully determined by the input sampled on the previous edge; the block SHALL hold no other history or state.
REQ-016 The outputs SHALL update on every clock edge, with no enable or handshake.
REQ-017 Boundary behaviour:
- N = 4: `counter` = 00, `overcrowd` = 1.
- N = 8: `count` = 8, `counter` = 00, `overcrowd` = 1.
- N = 3: `counter` = 11, `overcrowd` = 0.

Reset
REQ-018 When `reset` = 1 at a rising `Clock` edge, the block SHALL set `counter` = 2'b00, `count` = 4'd0 and `overcrowd` = 0, regardless of `neighborDot`.
REQ-019 Reset SHALL take priority over any simultaneous input change.
REQ-020 On the first edge with `reset` = 0, the outputs SHALL reflect `neighborDot` sampled at that edge.
REQ-021 Asserting reset mid-stream SHALL clear the outputs on that edge, with no partial update.
REQ-022 Before the first reset the output values are unspecified; benches SHALL apply reset before checking.

Verification
REQ-023 The bench SHALL cover the following directed scenarios, each checked one edge after the input is applied:
- `reset` = 1 with `neighborDot` = 8'hFF -> `counter` = 00, `count` = 0, `overcrowd` = 0.
- `neighborDot` = 8'b00000001, then 8'b00000010, then 8'b00000100 -> each gives `counter` = 01, `count` = 1, `overcrowd` = 0.
- `neighborDot` = 8'b00000011 -> `counter` = 10, `count` = 2.
- `neighborDot` = 8'b00000111 -> `counter` = 11, `count` = 3, `overcrowd` = 0.
- `neighborDot` = 8'b00111111 -> `counter` = 00, `count` = 6, `overcrowd` = 1.
- `neighborDot` = 8'hFF -> `count` = 8, `counter` = 00, `overcrowd` = 1.
- Apply 8'b00000111 and assert `reset` on the same edge -> all outputs zero.
REQ-024 The bench SHALL run an exhaustive sweep of all 256 `neighborDot` values against a reference popcount model, checking REQ-010 to REQ-012 with 1-cycle latency.
